// File: rtl/vga_rx_timing.sv
// ---------------------------------------------------------------------------
// vga_rx_timing
//
// Receive-side timing recovery for 640x480 VGA (800x525 total). Samples the
// incoming syncs and 4-4-4 colour on the pixel clock. It recovers the
// horizontal/vertical counters from the sync falls and locks to the expected
// timing. It reports pixel position, active-video valid and 3-3-2 colour, with
// a 2-cycle latency from the input pins.
//
// Optional feature (compile-time macro VGA_RX_BLANK_CHECK_EN):
//   when defined, any non-zero colour seen while locked and outside the active
//   area sets the sticky blank_err flag; when undefined blank_err is tied 0.
//
// Ports:
//   vgaclk       in   pixel clock (25 MHz)
//   rst_n        in   asynchronous active-low reset
//   hsync_in     in   incoming hsync, active-low pulse
//   vsync_in     in   incoming vsync, active-low pulse
//   red_in       in   4-bit red
//   green_in     in   4-bit green
//   blue_in      in   4-bit blue
//   pix_x        out  recovered horizontal count
//   pix_y        out  recovered vertical count
//   pix_valid    out  locked and inside the active area
//   pix_red      out  red_in[3:1]
//   pix_green    out  green_in[3:1]
//   pix_blue     out  blue_in[3:2]
//   frame_start  out  one-cycle pulse with pixel (0,0)
//   locked       out  in LOCKED state
//   err_cnt      out  saturating count of lock losses
//   blank_err    out  sticky non-zero-colour-in-blanking flag
//
// state   | meaning
// --------+-----------------------------------------------------------------
// SEARCH  | no timing reference; waiting for the first hsync fall
// H_ALIGN | hc aligned to hsync; counting good lines, waiting for vsync fall
// LOCKED  | both counters aligned; every sync fall is checked against them
// ---------------------------------------------------------------------------
module vga_rx_timing #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int LOCK_LINES = 4
) (
    input  logic       vgaclk,
    input  logic       rst_n,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [3:0] red_in,
    input  logic [3:0] green_in,
    input  logic [3:0] blue_in,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       pix_valid,
    output logic [2:0] pix_red,
    output logic [2:0] pix_green,
    output logic [1:0] pix_blue,
    output logic       frame_start,
    output logic       locked,
    output logic [7:0] err_cnt,
    output logic       blank_err
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int TMO_CYC  = H_TOTAL + 8;
    localparam int MW       = $clog2(LOCK_LINES + 1);
    localparam int TW       = $clog2(TMO_CYC);

    localparam logic [9:0]    HC_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]    VC_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]    HC_SYNC    = 10'(HS_START);
    localparam logic [9:0]    HC_SYNC1   = 10'(HS_START + 1);
    localparam logic [9:0]    VC_SYNC    = 10'(VS_START);
    localparam logic [9:0]    HC_ACT     = 10'(H_ACTIVE);
    localparam logic [9:0]    VC_ACT     = 10'(V_ACTIVE);
    localparam logic [MW-1:0] MATCH_FULL = MW'(LOCK_LINES);
    localparam logic [TW-1:0] TMO_LOAD   = TW'(TMO_CYC - 1);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        H_ALIGN = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t         state;
    logic           s_hsync, s_vsync, p_hsync, p_vsync;
    logic [3:0]     s_red, s_green, s_blue;
    logic [9:0]     hc, vc;
    logic [MW-1:0]  match;
    logic [TW-1:0]  tmr;

    logic           hs_fall, vs_fall;
    logic [9:0]     hc_inc, vc_inc, vc_cur;
    logic           vs_align, lock_err, timeout, in_active;

    always_ff @(posedge vgaclk or negedge rst_n) begin
        if (!rst_n) begin
            s_hsync <= 1'b0;
            s_vsync <= 1'b0;
            p_hsync <= 1'b0;
            p_vsync <= 1'b0;
            s_red   <= '0;
            s_green <= '0;
            s_blue  <= '0;
        end else begin
            s_hsync <= hsync_in;
            s_vsync <= vsync_in;
            p_hsync <= s_hsync;
            p_vsync <= s_vsync;
            s_red   <= red_in;
            s_green <= green_in;
            s_blue  <= blue_in;
        end
    end

    assign hs_fall = !s_hsync && p_hsync;
    assign vs_fall = !s_vsync && p_vsync;

    assign hc_inc = (hc == HC_LAST) ? 10'd0 : hc + 10'd1;
    assign vc_inc = (hc != HC_LAST) ? vc : ((vc == VC_LAST) ? 10'd0 : vc + 10'd1);

    // The vsync fall that completes alignment defines this cycle as the first
    // sync line, so the forced value is also what the output stage sees.
    assign vs_align = (state == H_ALIGN) && vs_fall && !hs_fall &&
                      (match == MATCH_FULL) && (hc == 10'd0);
    assign vc_cur   = vs_align ? VC_SYNC : vc;

    assign lock_err = (state == LOCKED) &&
                      ((hs_fall && vs_fall) ||
                       (hs_fall && (hc != HC_SYNC)) ||
                       (vs_fall && !((hc == 10'd0) && (vc == VC_SYNC))));

    // tmr reaching zero without a fall marks the TMO_CYC-th silent cycle.
    assign timeout = (state != SEARCH) && !hs_fall && (tmr == '0);

    assign in_active = (hc < HC_ACT) && (vc < VC_ACT);

    always_ff @(posedge vgaclk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SEARCH;
            hc      <= '0;
            vc      <= '0;
            match   <= '0;
            tmr     <= '0;
            err_cnt <= '0;
            locked  <= 1'b0;
        end else begin
            if (hs_fall) begin
                tmr <= TMO_LOAD;
            end else if (tmr != '0) begin
                tmr <= tmr - TW'(1);
            end

            if (lock_err || timeout) begin
                state  <= SEARCH;
                locked <= 1'b0;
                match  <= '0;
                hc     <= hc_inc;
                vc     <= '0;
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end else begin
                case (state)
                    SEARCH: begin
                        vc <= '0;
                        if (hs_fall) begin
                            hc    <= HC_SYNC1;
                            match <= MW'(1);
                            state <= H_ALIGN;
                        end else begin
                            hc <= hc_inc;
                        end
                    end
                    H_ALIGN: begin
                        hc <= hc_inc;
                        vc <= vc_inc;
                        if (hs_fall) begin
                            if (hc == HC_SYNC) begin
                                if (match != MATCH_FULL) begin
                                    match <= match + MW'(1);
                                end
                            end else begin
                                hc    <= HC_SYNC1;
                                match <= MW'(1);
                            end
                        end else if (vs_align) begin
                            vc     <= VC_SYNC;
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        hc <= hc_inc;
                        vc <= vc_inc;
                    end
                    default: begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge vgaclk or negedge rst_n) begin
        if (!rst_n) begin
            pix_x       <= '0;
            pix_y       <= '0;
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            pix_red     <= '0;
            pix_green   <= '0;
            pix_blue    <= '0;
        end else begin
            pix_x       <= hc;
            pix_y       <= vc_cur;
            pix_valid   <= (state == LOCKED) && in_active;
            frame_start <= (state == LOCKED) && (hc == 10'd0) && (vc == 10'd0);
            pix_red     <= s_red[3:1];
            pix_green   <= s_green[3:1];
            pix_blue    <= s_blue[3:2];
        end
    end

`ifdef VGA_RX_BLANK_CHECK_EN
    always_ff @(posedge vgaclk or negedge rst_n) begin
        if (!rst_n) begin
            blank_err <= 1'b0;
        end else if ((state == LOCKED) && !in_active &&
                     ((s_red != 4'd0) || (s_green != 4'd0) || (s_blue != 4'd0))) begin
            blank_err <= 1'b1;
        end
    end
`else
    // Colour LSBs only matter to the blanking check.
    logic unused_lsb;
    assign unused_lsb = ^{s_red[0], s_green[0], s_blue[1:0]};
    assign blank_err  = 1'b0;
`endif

endmodule

// File: tb/tb_vga_rx_timing.sv
`timescale 1ns/1ps
module tb_vga_rx_timing;

    // Full horizontal timing; a short vertical frame keeps runs small.
    localparam int HA = 640, HFP = 16, HSW = 96, HBP = 48;
    localparam int VA = 2, VFP = 2, VSW = 1, VBP = 1, LL = 4;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int HS0 = HA + HFP;
    localparam int VS0 = VA + VFP;
    localparam int FRAME = HT * VT;
`ifdef VGA_RX_BLANK_CHECK_EN
    localparam logic BLANK_EXP = 1'b1;
`else
    localparam logic BLANK_EXP = 1'b0;
`endif

    logic       vgaclk, rst_n, hsync_in, vsync_in;
    logic [3:0] red_in, green_in, blue_in;
    logic [9:0] pix_x, pix_y;
    logic       pix_valid, frame_start, locked, blank_err;
    logic [2:0] pix_red, pix_green;
    logic [1:0] pix_blue;
    logic [7:0] err_cnt;

    vga_rx_timing #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .LOCK_LINES(LL)
    ) dut (
        .vgaclk(vgaclk), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
        .pix_red(pix_red), .pix_green(pix_green), .pix_blue(pix_blue),
        .frame_start(frame_start), .locked(locked), .err_cnt(err_cnt),
        .blank_err(blank_err)
    );

    initial vgaclk = 1'b0;
    always #20 vgaclk = ~vgaclk;

    typedef struct {
        logic [9:0] x, y;
        logic       v, fs;
        logic [2:0] r, g;
        logic [1:0] b;
    } exp_t;

    typedef struct {
        logic [3:0] r, g, b;
        logic [2:0] er, eg;
        logic [1:0] eb;
    } cvec_t;

    int   n_cmp = 0, n_bad = 0;
    int   cyc = 0, gx = 0, gy = 0, fall_cyc = 0;
    bit   hs_stop = 0, shift_pend = 0, shift_cur = 0, ov_en = 0, trk = 0;
    logic [3:0] ov_r = 0, ov_g = 0, ov_b = 0;
    logic prev_hs = 1'b1;
    int   trk_err = 0, valid_cnt = 0, fs_cnt = 0, first_x = -1, first_y = -1;
    exp_t hist0, hist1;
    cvec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One pixel clock: sample outputs (they belong to the pins driven two
    // steps earlier), then drive the next generator pixel.
    task automatic step();
        logic [9:0] xv;
        logic [3:0] r, g, b;
        logic hs, vs;
        int hs_beg;
        @(negedge vgaclk);
        cyc++;
        if (trk) begin
            if (pix_x !== hist1.x || pix_y !== hist1.y || pix_valid !== hist1.v ||
                frame_start !== hist1.fs || pix_red !== hist1.r || pix_green !== hist1.g ||
                pix_blue !== hist1.b || locked !== 1'b1) begin
                if (trk_err == 0) begin
                    first_x = int'(hist1.x);
                    first_y = int'(hist1.y);
                end
                trk_err++;
            end
            if (pix_valid === 1'b1) valid_cnt++;
            if (frame_start === 1'b1) fs_cnt++;
        end
        if (gx == 0) begin
            shift_cur  = shift_pend;
            shift_pend = 0;
        end
        xv = 10'(gx);
        hs_beg = shift_cur ? HS0 + 4 : HS0;
        hs = hs_stop ? 1'b1 : !(gx >= hs_beg && gx < hs_beg + HSW);
        vs = !(gy >= VS0 && gy < VS0 + VSW);
        if (ov_en) begin
            r = ov_r; g = ov_g; b = ov_b;
        end else if (gx < HA && gy < VA) begin
            r = {xv[2:0], 1'b0}; g = xv[3:0]; b = {xv[1:0], 2'b00};
        end else begin
            r = 4'd0; g = 4'd0; b = 4'd0;
        end
        hsync_in = hs; vsync_in = vs;
        red_in = r; green_in = g; blue_in = b;
        if (prev_hs && !hs) fall_cyc = cyc;
        prev_hs = hs;
        hist1 = hist0;
        hist0.x = xv;
        hist0.y = 10'(gy);
        hist0.v = (gx < HA && gy < VA);
        hist0.fs = (gx == 0 && gy == 0);
        hist0.r = r[3:1]; hist0.g = g[3:1]; hist0.b = b[3:2];
        gx++;
        if (gx == HT) begin
            gx = 0;
            gy = (gy == VT - 1) ? 0 : gy + 1;
        end
    endtask

    // Advance until (x,y) is the next generator pixel to be driven.
    task automatic goto(input int x, input int y);
        while (!(gx == x && gy == y)) step();
    endtask

    task automatic wait_lock(input string tag, input int budget);
        int n = 0;
        while (locked !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_locked"}, 32'(locked), 32'd1);
        if (locked === 1'b1) begin
            chk({tag, "_lock_x"}, 32'(pix_x), 32'd0);
            chk({tag, "_lock_y"}, 32'(pix_y), 32'(VS0));
        end
    endtask

    task automatic run_frame_tracked(input string tag);
        while (!(hist1.x == 10'd0 && hist1.y == 10'd0)) step();
        trk_err = 0; valid_cnt = 0; fs_cnt = 0; first_x = -1; first_y = -1;
        trk = 1;
        repeat (FRAME) step();
        trk = 0;
        chk({tag, "_valid_cycles"}, 32'(valid_cnt), 32'(HA * VA));
        chk({tag, "_frame_start_pulses"}, 32'(fs_cnt), 32'd1);
        if (trk_err != 0)
            $display("FAIL %s_pixel_stream: %0d bad cycles, first at expected x=%0d y=%0d, required 0",
                     tag, trk_err, first_x, first_y);
        n_cmp++;
        if (trk_err != 0) n_bad++;
    endtask

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{4'hF, 4'hF, 4'hF, 3'd7, 3'd7, 2'd3};
        tbl[1] = '{4'h0, 4'h0, 4'h0, 3'd0, 3'd0, 2'd0};
        tbl[2] = '{4'h1, 4'h1, 4'h1, 3'd0, 3'd0, 2'd0};
        tbl[3] = '{4'h2, 4'h3, 4'h4, 3'd1, 3'd1, 2'd1};
        tbl[4] = '{4'h8, 4'h9, 4'hC, 3'd4, 3'd4, 2'd3};
        tbl[5] = '{4'hE, 4'h6, 4'h7, 3'd7, 3'd3, 2'd1};
        tbl[6] = '{4'h5, 4'hA, 4'hB, 3'd2, 3'd5, 2'd2};
        tbl[7] = '{4'hC, 4'h0, 4'h8, 3'd6, 3'd0, 2'd2};
        hist0 = '{10'd0, 10'd0, 1'b0, 1'b0, 3'd0, 3'd0, 2'd0};
        hist1 = hist0;

        rst_n = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        red_in = 4'd0; green_in = 4'd0; blue_in = 4'd0;
        repeat (3) @(negedge vgaclk);
        chk("rst_pix_x", 32'(pix_x), 0);
        chk("rst_pix_y", 32'(pix_y), 0);
        chk("rst_pix_valid", 32'(pix_valid), 0);
        chk("rst_frame_start", 32'(frame_start), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        chk("rst_blank_err", 32'(blank_err), 0);
        chk("rst_colour", 32'({pix_red, pix_green, pix_blue}), 0);
        rst_n = 1'b1;

        // Ideal timing from pixel (0,0): lock on the first vsync fall.
        wait_lock("init", 2 * FRAME);
        chk("init_err_cnt", 32'(err_cnt), 0);
        run_frame_tracked("frame1");

        // Colour reduction vectors across consecutive active pixels.
        goto(100, 0);
        for (int i = 0; i < 10; i++) begin
            ov_en = (i < 8);
            if (i < 8) begin
                ov_r = tbl[i].r; ov_g = tbl[i].g; ov_b = tbl[i].b;
            end
            step();
            if (i >= 2)
                chk($sformatf("colour_vec%0d{valid,x,r,g,b}", i - 2),
                    32'({pix_valid, pix_x, pix_red, pix_green, pix_blue}),
                    32'({1'b1, 10'(100 + i - 2), tbl[i-2].er, tbl[i-2].eg, tbl[i-2].eb}));
        end
        ov_en = 0;

        // Non-zero red in horizontal blanking.
        chk("blank_err_clear", 32'(blank_err), 0);
        goto(700, 0);
        ov_en = 1; ov_r = 4'h2; ov_g = 4'h0; ov_b = 4'h0;
        step();
        ov_en = 0;
        repeat (3) step();
        chk("blank_err_set", 32'(blank_err), 32'(BLANK_EXP));
        goto(0, 1);
        step();
        chk("blank_err_sticky", 32'(blank_err), 32'(BLANK_EXP));
        chk("blank_keeps_lock", 32'(locked), 1);

        // One hsync fall late by 4 pixels.
        goto(0, 2);
        shift_pend = 1;
        goto(HS0 + 5, 2);
        step();
        chk("hshift_hold", 32'(locked), 1);
        step();
        chk("hshift_drop", 32'(locked), 0);
        chk("hshift_err_cnt", 32'(err_cnt), 1);
        wait_lock("relock_hshift", 3 * FRAME);
        chk("relock_hshift_err_cnt", 32'(err_cnt), 1);

        // Hsync held high: drop on the 808th cycle without a fall.
        goto(0, 0);
        hs_stop = 1;
        while (cyc < fall_cyc + HT + 9) step();
        chk("timeout_hold", 32'(locked), 1);
        step();
        chk("timeout_drop", 32'(locked), 0);
        chk("timeout_err_cnt", 32'(err_cnt), 2);
        goto(0, 1);
        hs_stop = 0;
        wait_lock("relock_timeout", 3 * FRAME);
        chk("relock_timeout_err_cnt", 32'(err_cnt), 2);

        // Reset in the middle of an active line.
        goto(300, 1);
        chk("pre_reset_valid", 32'(pix_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_locked", 32'(locked), 0);
        chk("midrst_pix_valid", 32'(pix_valid), 0);
        chk("midrst_err_cnt", 32'(err_cnt), 0);
        chk("midrst_blank_err", 32'(blank_err), 0);
        repeat (3) step();
        rst_n = 1'b1;
        wait_lock("relock_reset", 3 * FRAME);
        chk("relock_reset_err_cnt", 32'(err_cnt), 0);
        run_frame_tracked("frame_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_rx_timing.md
Name: vga_rx_timing

Overview:
- Receive-side counterpart of the team's 640x480 VGA timing generator. Samples incoming hsync/vsync and 4-4-4 RGB on the same 25 MHz pixel clock.
- Recovers the horizontal and vertical pixel counters and locks to the expected 800x525 timing.
- Emits pixel position, active-video valid, and colour reduced back to 3-3-2.
- Used for loopback self-test and for capturing generator output into graphics-side logic.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse length
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse length
- V_BP, 33, vertical back porch
- LOCK_LINES, 4, consecutive correctly timed hsync falls required before vertical alignment

Ports:
- vgaclk  in  1  pixel clock, 25 MHz
- rst_n  in  1  asynchronous active-low reset
- hsync_in  in  1  incoming hsync, active-low pulse
- vsync_in  in  1  incoming vsync, active-low pulse
- red_in  in  4  incoming red
- green_in  in  4  incoming green
- blue_in  in  4  incoming blue
- pix_x  out  10  recovered horizontal count
- pix_y  out  10  recovered vertical count
- pix_valid  out  1  locked and inside the active area
- pix_red  out  3  red_in[3:1]
- pix_green  out  3  green_in[3:1]
- pix_blue  out  2  blue_in[3:2]
- frame_start  out  1  one-cycle pulse coincident with pixel (0,0)
- locked  out  1  in LOCKED state
- err_cnt  out  8  saturating count of lock losses
- blank_err  out  1  sticky flag for non-zero RGB during blanking (see Optional Feature)

Behaviour:
- Derived values: H_TOTAL = 800, V_TOTAL = 525, HS_START = H_ACTIVE + H_FP = 656, VS_START = V_ACTIVE + V_FP = 490.
- Input stage: all inputs are registered once (s_*), plus a second hsync/vsync register for edge detection.
- Falling edge: s == 0 and previous == 1.
- Internal hc/vc track the sample in the s_* stage.
  - hc wraps 799 -> 0.
  - vc increments on hc wrap and wraps 524 -> 0.
- Reset (async, rst_n = 0): all registers 0; state SEARCH; every output 0.
- SEARCH:
  - vc is held at 0.
  - On an hsync fall, hc is forced so the fall cycle counts as 656 (next hc = 657); load match count = 1; go to H_ALIGN.
- H_ALIGN:
  - hsync fall with hc == 656: match count increments, saturating at LOCK_LINES.
  - hsync fall with hc != 656: realign hc, match count = 1.
  - vsync fall with match count == LOCK_LINES and hc == 0: vc is forced to 490 for that cycle; go to LOCKED.
  - vsync fall before LOCK_LINES is reached: ignored.
- LOCKED:
  - hsync fall must occur with hc == 656.
  - vsync fall must occur with hc == 0 and vc == 490.
  - Any mismatch, including an hsync and vsync fall in the same cycle: go to SEARCH, err_cnt += 1 (saturates at 255), locked drops next cycle.
- Timeout, any state except SEARCH: no hsync fall for H_TOTAL + 8 consecutive cycles -> SEARCH, err_cnt += 1.
- Output stage: one register after the s_* stage. Latency from input pins to pix_* is 2 cycles.
  - pix_x/pix_y = hc/vc.
  - pix_valid = locked && hc < H_ACTIVE && vc < V_ACTIVE.
  - frame_start = locked && hc == 0 && vc == 0.
  - pix_red/green/blue are always passed through (upper bits); consumers qualify with pix_valid.
- locked is asserted from the cycle after the LOCKED transition.
- Rising sync edges are not checked.
- err_cnt and blank_err clear only on reset.

Optional Feature:
- Macro VGA_RX_BLANK_CHECK_EN.
- When defined:
  - While locked and outside the active area, any non-zero s_red/s_green/s_blue sets blank_err (sticky).
  - Lock is unaffected.
- When undefined: blank_err is tied 0 and no check logic is built.

Test Plan:
- Reset mid-frame (rst_n low for 3 cycles while locked) -> locked = 0, pix_valid = 0, err_cnt = 0 immediately; relock on the following frame.
- Drive ideal 800x525 timing starting at hc = 0, vc = 0 -> locked asserts after ≥4 hsync falls and the first vsync fall; frame_start pulses exactly when input pixel (0,0) appears 2 cycles later; pix_valid high for exactly 307200 cycles per frame.
- Locked, drive a colour ramp red_in = {x[2:0],0}, blue_in = {x[1:0],00} -> pix_red = x[2:0], pix_blue = x[1:0], pix_x = x, with 2-cycle latency.
- Locked, shift one hsync fall to hc = 660 -> locked drops the following cycle, err_cnt = 1, relock within the next frame.
- Locked, stop hsync (hold high) -> after 808 cycles, locked = 0 and err_cnt increments by 1.
- With VGA_RX_BLANK_CHECK_EN defined: red_in = 4'h2 at hc = 700 -> blank_err = 1 and stays 1; without the macro, blank_err = 0.
